// File: rtl/baud_pkg.sv
// Shared constants and handshake state type for the fractional baud generator.
package baud_pkg;

  localparam int unsigned DefN     = 16;
  localparam int unsigned DefFracW = 4;
  localparam int unsigned DefOvs   = 16;
  localparam int unsigned DefDiv   = 326;

  typedef enum logic {
    StIdle    = 1'b0,
    StPending = 1'b1
  } hs_state_e;

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional divisor accumulator: adds frac on each tick, carry stretches the next period.
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int unsigned FRAC_W = DefFracW
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_tick,
  input  logic              i_clear,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_carry
);

  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;
  logic [FRAC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, i_frac};

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (i_tick) begin
      {r_carry, r_acc} <= w_sum;
    end
  end

  assign o_carry = r_carry;

endmodule

// File: rtl/frac_baud_gen.sv
// Fractional-N baud tick generator with sample/bit ticks and a divisor update handshake.
// Define FRAC_BAUD_GEN_FRAC_EN to build the fractional accumulator; otherwise period = div_int.
module frac_baud_gen
  import baud_pkg::*;
#(
  parameter int unsigned N       = DefN,
  parameter int unsigned FRAC_W  = DefFracW,
  parameter int unsigned OVS     = DefOvs,
  parameter int unsigned DEF_DIV = DefDiv
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [N-1:0]      i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_div_valid,
  output logic              o_div_ready,
  output logic              o_sample_tick,
  output logic              o_bit_tick
);

  localparam int unsigned  SW       = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [SW-1:0] ScntLast = SW'(OVS - 1);
  localparam logic [N-1:0]  DefDivN  = N'(DEF_DIV);

  hs_state_e   r_state;
  logic        r_ready;
  logic [N-1:0]  r_div_int;
  logic [N-1:0]  r_pend_int;
  logic [N-1:0]  r_cnt;
  logic [SW-1:0] r_scnt;

  logic        w_carry;
  logic [N-1:0] w_div_eff;
  logic [N:0]  w_period_m1;
  logic        w_tick;
  logic        w_apply;
  logic        w_accept;

  assign w_div_eff   = (r_div_int == '0) ? N'(1) : r_div_int;
  assign w_period_m1 = {1'b0, w_div_eff} + (N+1)'(w_carry) - (N+1)'(1);
  assign w_tick      = i_enable && !i_reset && ({1'b0, r_cnt} == w_period_m1);
  // Pending divisor lands on the next tick, or immediately if the generator is idle.
  assign w_apply     = (r_state == StPending) && (w_tick || !i_enable);
  assign w_accept    = (r_state == StIdle) && i_div_valid;

`ifdef FRAC_BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] r_div_frac;
  logic [FRAC_W-1:0] r_pend_frac;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div_frac  <= '0;
      r_pend_frac <= '0;
    end else begin
      if (w_accept) r_pend_frac <= i_div_frac;
      if (w_apply)  r_div_frac  <= r_pend_frac;
    end
  end

  baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_tick  (w_tick),
    .i_clear (w_apply),
    .i_frac  (r_div_frac),
    .o_carry (w_carry)
  );
`else
  logic [FRAC_W-1:0] w_unused_frac;
  assign w_unused_frac = i_div_frac;
  assign w_carry       = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_ready    <= 1'b1;
      r_div_int  <= DefDivN;
      r_pend_int <= '0;
      r_cnt      <= '0;
      r_scnt     <= '0;
    end else begin
      if (w_apply) begin
        r_div_int <= r_pend_int;
        r_cnt     <= '0;
        r_scnt    <= '0;
      end else if (i_enable) begin
        if (w_tick) begin
          r_cnt  <= '0;
          r_scnt <= (r_scnt == ScntLast) ? '0 : r_scnt + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_pend_int <= i_div_int;
            r_state    <= StPending;
            r_ready    <= 1'b0;
          end
        end
        StPending: begin
          if (w_apply) begin
            r_state <= StIdle;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_div_ready   = r_ready;
  assign o_sample_tick = w_tick;
  assign o_bit_tick    = w_tick && (r_scnt == ScntLast);

endmodule

// File: tb/tb_frac_baud_gen.sv
// Self-checking bench for frac_baud_gen: directed scenarios plus random traffic vs a period model.
module tb_frac_baud_gen;

  localparam int N   = 16;
  localparam int FW  = 4;
  localparam int OVS = 16;
  localparam int DEF = 326;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          dv  = 1'b0;
  logic [N-1:0]  di  = '0;
  logic [FW-1:0] df  = '0;
  logic          tick;
  logic          bit_t;
  logic          ready;

  always #5 clk = ~clk;

  frac_baud_gen #(
    .N       (N),
    .FRAC_W  (FW),
    .OVS     (OVS),
    .DEF_DIV (DEF)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_div_int     (di),
    .i_div_frac    (df),
    .i_div_valid   (dv),
    .o_div_ready   (ready),
    .o_sample_tick (tick),
    .o_bit_tick    (bit_t)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: period k after a clear lasts div + (floor(k*F/2^W) - floor((k-1)*F/2^W)).
  int m_div = DEF, m_frac = 0, m_k = 0, m_el = 0;
  int m_pdiv = 0, m_pfrac = 0;
  bit m_pend = 0, m_ready_known = 0;
  bit obs_tick, obs_bit;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int extra_cycles(int k);
`ifdef FRAC_BAUD_GEN_FRAC_EN
    if (k == 0) return 0;
    return ((k * m_frac) >> FW) - (((k - 1) * m_frac) >> FW);
`else
    return 0 * k;
`endif
  endfunction

  task automatic step(input bit r, input bit e, input bit v, input int d_int, input int d_frac);
    int period;
    bit et, eb, acc_ok;
    @(posedge clk);
    #1;
    rst = r; en = e; dv = v;
    di = N'(d_int);
    df = FW'(d_frac);
    period = ((m_div == 0) ? 1 : m_div) + extra_cycles(m_k);
    et = !r && e && (m_el == period - 1);
    eb = et && ((m_k % OVS) == OVS - 1);
    @(negedge clk);
    check_val("sample_tick", tick, et);
    check_val("bit_tick", bit_t, eb);
    if (m_ready_known) check_val("div_ready", ready, !m_pend);
    obs_tick = tick;
    obs_bit  = bit_t;
    if (r) begin
      m_div = DEF; m_frac = 0; m_k = 0; m_el = 0; m_pend = 0; m_ready_known = 1;
    end else begin
      acc_ok = !m_pend && v;
      if (m_pend && (et || !e)) begin
        m_div = m_pdiv; m_frac = m_pfrac; m_k = 0; m_el = 0; m_pend = 0;
      end else if (e) begin
        if (et) begin m_k++; m_el = 0; end
        else m_el++;
      end
      if (acc_ok) begin
        m_pend = 1; m_pdiv = d_int % (1 << N); m_pfrac = d_frac % (1 << FW);
      end
    end
  endtask

  task automatic run_to_tick(input int limit, output int cycles);
    cycles = 0;
    do begin
      step(0, 1, 0, 0, 0);
      cycles++;
    end while (!obs_tick && cycles < limit);
    if (!obs_tick) check_val("tick_timeout", obs_tick, 1);
  endtask

  task automatic wait_ready(input int limit);
    int i = 0;
    do begin
      step(0, 1, 0, 0, 0);
      i++;
    end while (!ready && i < limit);
    check_val("ready_restored", ready, 1);
  endtask

  initial begin
    int first_tick, first_bit, c, total, n;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Defaults after reset
    first_tick = -1; first_bit = -1;
    for (int i = 1; i <= 5300; i++) begin
      step(0, 1, 0, 0, 0);
      if (obs_tick && first_tick < 0) first_tick = i;
      if (obs_bit && first_bit < 0) first_bit = i;
    end
    check_val("first_sample_tick", first_tick, DEF);
    check_val("first_bit_tick", first_bit, DEF * OVS);
    check_val("ready_after_reset", ready, 1);

    // 10 + 8/16: steady-state 32 periods
    step(0, 1, 1, 10, 8);
    wait_ready(400);
    run_to_tick(50, c);
    total = 0;
    for (int i = 0; i < 32; i++) begin
      run_to_tick(50, c);
      total += c;
    end
`ifdef FRAC_BAUD_GEN_FRAC_EN
    check_val("frac_32_ticks", total, 336);
`else
    check_val("int_32_ticks", total, 320);
`endif

    // Mid-period update to 4, second request while busy ignored
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 4, 0);
    check_val("ready_low_pending", ready, 1);
    step(0, 1, 1, 7, 3);
    check_val("ready_low_busy", ready, 0);
    wait_ready(40);
    n = 0;
    do begin
      run_to_tick(20, c);
      n++;
      if (n >= 2) check_val("period_div4", c, 4);
    end while (!obs_bit && n < 20);
    check_val("ticks_to_bit_after_update", n, OVS);

    // Disable for 50 cycles mid-period
    step(0, 1, 1, 20, 0);
    wait_ready(20);
    run_to_tick(40, c);
    repeat (5) step(0, 1, 0, 0, 0);
    repeat (50) step(0, 0, 0, 0, 0);
    run_to_tick(100, c);
    check_val("disabled_period", 5 + 50 + c, 20 + 50);

    // Pending update applied while disabled
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 6, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_val("ready_after_disable_apply", ready, 1);
    run_to_tick(20, c);
    check_val("period_after_disable_apply", c, 6);

    // Reset while pending
    step(0, 1, 1, 9, 0);
    step(1, 1, 0, 0, 0);
    run_to_tick(400, c);
    check_val("period_after_pending_reset", c, DEF);
    check_val("ready_after_pending_reset", ready, 1);

    // div_int = 1 -> tick every cycle
    step(0, 1, 1, 1, 0);
    wait_ready(400);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 0);
      check_val("tick_every_cycle", obs_tick, 1);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 999) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 12), $urandom_range(0, 15));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frac_baud_gen.md
FRAC_BAUD_GEN -- requirements
Module: frac_baud_gen

Interface
REQ-001 Parameter N, default 16: width of the integer divisor and of the cycle counter.
REQ-002 Parameter FRAC_W, default 4: width of the fractional divisor, in 1/2^FRAC_W units.
REQ-003 Parameter OVS, default 16: sample ticks per bit tick; legal range 2..256.
REQ-004 Parameter DEF_DIV, default 326: integer divisor loaded at reset; legal range 1..2^N-1.
REQ-005 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_enable  input  1  1 = generator runs; 0 = counters hold and no ticks are produced.
REQ-008 i_div_int  input  N  requested integer divisor, in clock cycles per sample tick.
REQ-009 i_div_frac  input  FRAC_W  requested fractional divisor.
REQ-010 i_div_valid  input  1  divisor update request.
REQ-011 o_div_ready  output  1  an update is accepted on any cycle where i_div_valid and o_div_ready are both 1.
REQ-012 o_sample_tick  output  1  one-cycle pulse at the oversampling rate.
REQ-013 o_bit_tick  output  1  one-cycle pulse on every OVS-th sample tick.

Function
REQ-014 The block SHALL keep active divisor registers (div_int, div_frac), a cycle counter cnt[N-1:0], a fractional accumulator acc[FRAC_W-1:0], a carry bit, and a sample counter scnt[0..OVS-1].
REQ-015 The period SHALL be div_int + carry; an active div_int of 0 SHALL be treated as 1.
REQ-016 With i_enable=1, cnt SHALL increment each cycle; when cnt == period-1, o_sample_tick SHALL be 1 in that cycle and cnt SHALL return to 0 on the next edge.
REQ-017 On each sample tick, {carry, acc} SHALL be loaded with acc + div_frac, using an (FRAC_W+1)-bit sum; the carry therefore lengthens only the following period.
REQ-018 On each sample tick, scnt SHALL increment modulo OVS; o_bit_tick SHALL be 1 in the same cycle as the sample tick for which scnt == OVS-1.
REQ-019 With i_enable=0, cnt, acc, carry and scnt SHALL hold their values and both tick outputs SHALL be 0; counting SHALL resume from the held values when i_enable returns to 1.
REQ-020 Update handshake, state IDLE (o_div_ready=1): a valid&&ready cycle SHALL capture i_div_int and i_div_frac into pending registers and move the block to PENDING (o_div_ready=0).
REQ-021 In PENDING, the pending values SHALL become active and cnt, acc, carry and scnt SHALL be cleared on the edge ending either the next sample-tick cycle or the first cycle with i_enable=0, whichever comes first; the state then SHALL return to IDLE.
REQ-022 i_div_valid SHALL be ignored while o_div_ready=0, and the pending values SHALL NOT change in PENDING.
REQ-023 The tick that triggers an update SHALL still be emitted; the next period SHALL use the new divisor and carry=0.
REQ-024 With div_int=1, div_frac=0 and i_enable=1, o_sample_tick SHALL be 1 on every cycle.

Reset
REQ-025 With i_reset=1 at an edge: div_int=DEF_DIV, div_frac=0, cnt=0, acc=0, carry=0, scnt=0, state=IDLE; any pending update SHALL be discarded.
REQ-026 While i_reset=1, o_sample_tick=0 and o_bit_tick=0; o_div_ready=1 from the first cycle after reset.
REQ-027 After reset with i_enable held at 1, the first o_sample_tick SHALL occur on the DEF_DIV-th enabled cycle.

Configuration
REQ-028 Macro FRAC_BAUD_GEN_FRAC_EN defined: the fractional accumulator SHALL be built as specified above.
REQ-029 Macro FRAC_BAUD_GEN_FRAC_EN undefined: acc and carry SHALL NOT be built; i_div_frac SHALL be accepted but ignored; period SHALL equal div_int.

Structure
REQ-030 Package baud_pkg SHALL hold the handshake state enumeration (IDLE, PENDING) and the default constants for N, FRAC_W, OVS and DEF_DIV.
REQ-031 The fractional accumulator SHALL be a sub-module baud_frac_acc: inputs tick, clear, frac; output carry.

Verification
REQ-032 Reset, i_enable=1, defaults -> first o_sample_tick at cycle 326; o_bit_tick at cycle 326*16=5216; o_div_ready=1.
REQ-033 div_int=10, div_frac=8 (0.5), FRAC_W=4 -> sample periods alternate 10,11; 32 ticks take exactly 336 cycles.
REQ-034 Update to div_int=4 requested mid-period -> o_div_ready=0 until the tick edge; following periods are 4 cycles; scnt restarts at 0; a second valid while not ready is ignored.
REQ-035 i_enable=0 for 50 cycles mid-period -> no ticks; the tick arrives exactly 50 cycles late; a pending update is applied during the disable.
REQ-036 i_reset asserted while in PENDING -> DEF_DIV active, pending discarded, o_div_ready=1.
REQ-037 Build without FRAC_BAUD_GEN_FRAC_EN, div_int=10, div_frac=8 -> every period is 10 cycles.
